// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter and its shift core.
// Latency: none (package only).
// Backpressure: none (package only).
package shift_pkg;

    localparam int SHIFT_W = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        SHIFT_SRL = 2'b00,
        SHIFT_SLL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_RSV = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_t;

    function automatic logic [SHIFT_W-1:0] bitrev(input logic [SHIFT_W-1:0] v);
        logic [SHIFT_W-1:0] r;
        for (int i = 0; i < SHIFT_W; i++) begin
            r[i] = v[SHIFT_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_core.sv
// SRL/SLL/SRA on one right-logical barrel shifter via bit-reverse and fill select.
// Latency: purely combinational.
// Backpressure: none; holds no state.
module shift_core
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] in,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_op_t          op,
    output logic [SHIFT_W-1:0] out
);

    logic [SHIFT_W-1:0] pre;
    logic [SHIFT_W-1:0] x;
    logic               fill;

    always_comb begin
        pre  = (op == SHIFT_SLL) ? bitrev(in) : in;
        fill = (op == SHIFT_SRA) && in[SHIFT_W-1];
        x    = pre;
        // Stage k shifts by 2^k; vacated top bits take the fill bit.
        for (int k = 0; k < SHAMT_W; k++) begin
            if (shamt[k]) begin
                x = (x >> (1 << k)) | (fill ? ~({SHIFT_W{1'b1}} >> (1 << k)) : '0);
            end
        end
        out = (op == SHIFT_SLL) ? bitrev(x) : x;
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift core among NREQ requesters, tagged response.
// Latency: accept at T, resp_valid at T+2; one operation in flight, issue interval 3.
// Backpressure: response held stable until resp_ready; no accepts while busy.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter  int N    = 32,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_data,
    input  logic [NREQ*5-1:0] req_shamt,
    input  logic [NREQ*2-1:0] req_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [N-1:0]      resp_data,
    output logic [IDW-1:0]    resp_id,
    output logic              busy
);

    localparam logic [IDW:0]   NREQ_L = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

    arb_state_t       state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [NREQ-1:0]  rot;
    logic             found;
    logic [IDW-1:0]   off;
    logic [IDW:0]     sum;
    logic [IDW-1:0]   gnt;
    logic [N-1:0]     sel_data;
    logic [4:0]       sel_shamt;
    logic [1:0]       sel_op;
    logic             accept;

    logic [N-1:0]     op_data;
    logic [4:0]       op_shamt;
    shift_op_t        op_op;
    logic [IDW-1:0]   op_id;
    logic [N-1:0]     core_out;

    // Rotate so bit 0 is the requester at rr_ptr, then take the lowest set bit.
    always_comb begin
        rot   = NREQ'({req_valid, req_valid} >> rr_ptr);
        found = 1'b0;
        off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = IDW'(k);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        gnt = (sum >= NREQ_L) ? IDW'(sum - NREQ_L) : sum[IDW-1:0];
    end

    always_comb begin
        sel_data  = '0;
        sel_shamt = '0;
        sel_op    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt == IDW'(k)) begin
                sel_data  = req_data[k*N +: N];
                sel_shamt = req_shamt[k*5 +: 5];
                sel_op    = req_op[k*2 +: 2];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (found && rst_n) begin
                    req_ready[gnt] = 1'b1;
                    accept         = 1'b1;
                    state_nxt      = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_data   <= '0;
            op_shamt  <= '0;
            op_op     <= SHIFT_SRL;
            op_id     <= '0;
            resp_data <= '0;
            resp_id   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_data  <= sel_data;
                op_shamt <= sel_shamt;
                op_op    <= shift_op_t'(sel_op);
                op_id    <= gnt;
                rr_ptr   <= (gnt == LAST) ? '0 : gnt + IDW'(1);
            end
            if (state == EXEC) begin
                resp_data <= core_out;
                resp_id   <= op_id;
            end
        end
    end

    shift_core u_core (
        .in    (op_data),
        .shamt (op_shamt),
        .op    (op_op),
        .out   (core_out)
    );

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: reference model predicts grants/results,
// a negedge monitor compares every cycle and on each response transfer.
module tb_shift_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [19:0]  req_shamt;
    logic [7:0]   req_op;
    logic         resp_valid;
    logic         resp_ready;
    logic [31:0]  resp_data;
    logic [1:0]   resp_id;
    logic         busy;

    always #5 clk = ~clk;

    shift_arbiter #(.N(32), .NREQ(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_shamt  (req_shamt),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    function automatic int pick(input logic [3:0] v, input int rr);
        for (int k = 0; k < 4; k++) begin
            if (v[(rr + k) % 4]) return (rr + k) % 4;
        end
        return 0;
    endfunction

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic [1:0] o);
        case (o)
            2'b01:   return d << s;
            2'b10:   return $signed(d) >>> s;
            default: return d >> s;
        endcase
    endfunction

    // Reference model: one op in flight; RESP from the second cycle after accept.
    bit          m_idle = 1'b1;
    int          m_rr = 0;
    int          m_cnt = 0;
    bit          m_gnt_vld = 1'b0;
    int          m_gnt = 0;
    logic [31:0] exp_dat [0:1023];
    int          exp_id  [0:1023];
    int          wr_idx = 0;
    int          flush_to = 0;

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_idle    = 1'b1;
            m_rr      = 0;
            m_cnt     = 0;
            m_gnt_vld = 1'b0;
            flush_to  = wr_idx;
        end else begin
            m_gnt_vld = 1'b0;
            if (!m_idle) begin
                if (m_cnt >= 1 && resp_ready) m_idle = 1'b1;
                else m_cnt = 1;
            end else if (|req_valid) begin
                g = pick(req_valid, m_rr);
                exp_dat[wr_idx % 1024] = ref_shift(req_data[g*32 +: 32], req_shamt[g*5 +: 5],
                                                   req_op[g*2 +: 2]);
                exp_id[wr_idx % 1024]  = g;
                wr_idx    = wr_idx + 1;
                m_gnt_vld = 1'b1;
                m_gnt     = g;
                m_rr      = (g + 1) % 4;
                m_idle    = 1'b0;
                m_cnt     = 0;
            end
        end
    end

    // Directed checks posted by the stimulus, evaluated by the monitor.
    string       chk_name [0:255];
    logic [31:0] chk_got  [0:255];
    logic [31:0] chk_exp  [0:255];
    int          chk_n = 0;
    int          chk_done = 0;

    int          rd_idx = 0;
    int          seen_n = 0;
    int          seen_id  [0:255];
    logic [31:0] seen_dat [0:255];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] erdy;
        logic       evld;
        if (rd_idx < flush_to) rd_idx = flush_to;
        erdy = 4'b0;
        if (rst_n && m_idle && |req_valid) erdy[pick(req_valid, m_rr)] = 1'b1;
        evld = rst_n && !m_idle && (m_cnt >= 1);
        check("req_ready", 32'(req_ready), 32'(erdy));
        check("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        check("resp_valid", 32'(resp_valid), 32'(evld));
        check("busy", 32'(busy), 32'(rst_n && !m_idle));
        if (resp_valid && evld) begin
            if (rd_idx >= wr_idx) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                check("resp_data", resp_data, exp_dat[rd_idx % 1024]);
                check("resp_id", 32'(resp_id), 32'(exp_id[rd_idx % 1024]));
                if (resp_ready) begin
                    seen_id[seen_n % 256]  = int'(resp_id);
                    seen_dat[seen_n % 256] = resp_data;
                    seen_n = seen_n + 1;
                    rd_idx = rd_idx + 1;
                end
            end
        end
        while (chk_done < chk_n) begin
            check(chk_name[chk_done % 256], chk_got[chk_done % 256], chk_exp[chk_done % 256]);
            chk_done++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic post(input string nm, input logic [31:0] got, input logic [31:0] exp);
        chk_name[chk_n % 256] = nm;
        chk_got[chk_n % 256]  = got;
        chk_exp[chk_n % 256]  = exp;
        chk_n = chk_n + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] s,
                           input logic [1:0] o);
        req_data[i*32 +: 32] = d;
        req_shamt[i*5 +: 5]  = s;
        req_op[i*2 +: 2]     = o;
    endtask

    task automatic set_rand(input int i);
        set_req(i, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    endtask

    task automatic wait_grant(input int i);
        for (int t = 0; t < 50; t++) begin
            step();
            if (m_gnt_vld && m_gnt == i) return;
        end
        post("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_seen(input int n);
        for (int t = 0; t < 100; t++) begin
            if (seen_n >= n) return;
            step();
        end
        post("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100; t++) begin
            if (m_idle) return;
            step();
        end
        post("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [31:0] t_d   [0:7] = '{32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0,
                                 32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0, 32'h0000_0003};
    logic [4:0]  t_s   [0:7] = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd31};
    logic [1:0]  t_o   [0:7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01};
    logic [31:0] t_exp [0:7] = '{32'h0800_000F, 32'h0000_0F00, 32'hF800_000F, 32'h0800_000F,
                                 32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0, 32'h8000_0000};

    initial begin
        int base;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_shamt  = '0;
        req_op     = '0;
        resp_ready = 1'b0;
        #2;
        post("rst_resp_valid", 32'(resp_valid), 32'd0);
        post("rst_busy", 32'(busy), 32'd0);
        post("rst_req_ready", 32'(req_ready), 32'd0);
        post("rst_resp_data", resp_data, 32'd0);
        post("rst_resp_id", 32'(resp_id), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Op coverage through requester 0.
        resp_ready = 1'b1;
        base = seen_n;
        for (int k = 0; k < 8; k++) begin
            set_req(0, t_d[k], t_s[k], t_o[k]);
            req_valid[0] = 1'b1;
            wait_grant(0);
            req_valid[0] = 1'b0;
            wait_seen(base + k + 1);
            post("op_result", seen_dat[(base + k) % 256], t_exp[k]);
        end
        wait_idle();

        // Round robin with all requesters continuously valid.
        do_reset();
        base = seen_n;
        for (int i = 0; i < 4; i++) set_rand(i);
        req_valid = 4'hF;
        for (int t = 0; t < 200 && seen_n < base + 8; t++) begin
            step();
            if (m_gnt_vld) set_rand(m_gnt);
        end
        req_valid = '0;
        for (int k = 0; k < 8; k++) post("rr_order", 32'(seen_id[(base + k) % 256]), 32'(k % 4));
        wait_idle();

        // Backpressure: hold resp_ready low through RESP while req2 waits.
        resp_ready = 1'b0;
        base = seen_n;
        set_rand(1);
        req_valid[1] = 1'b1;
        wait_grant(1);
        req_valid[1] = 1'b0;
        set_rand(2);
        req_valid[2] = 1'b1;
        repeat (6) step();
        post("bp_resp_valid", 32'(resp_valid), 32'd1);
        post("bp_req_ready", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        wait_grant(2);
        req_valid[2] = 1'b0;
        wait_seen(base + 2);
        post("bp_id0", 32'(seen_id[base % 256]), 32'd1);
        post("bp_id1", 32'(seen_id[(base + 1) % 256]), 32'd2);
        wait_idle();

        // Skip idle requesters: rr_ptr=1, only req3 and req0 valid.
        do_reset();
        base = seen_n;
        set_rand(0);
        req_valid[0] = 1'b1;
        wait_grant(0);
        req_valid[0] = 1'b0;
        wait_seen(base + 1);
        wait_idle();
        set_rand(0);
        set_rand(3);
        req_valid = 4'b1001;
        for (int t = 0; t < 100 && seen_n < base + 3; t++) begin
            step();
            if (m_gnt_vld) req_valid[m_gnt] = 1'b0;
        end
        req_valid = '0;
        post("skip_first", 32'(seen_id[(base + 1) % 256]), 32'd3);
        post("skip_second", 32'(seen_id[(base + 2) % 256]), 32'd0);
        wait_idle();

        // Randomized traffic with random backpressure.
        for (int t = 0; t < 400; t++) begin
            step();
            if (m_gnt_vld) req_valid[m_gnt] = 1'b0;
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_rand(i);
                    req_valid[i] = 1'b1;
                end
            end
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        wait_idle();
        step();

        // Asynchronous reset during EXEC discards the op; req2 re-arbitrates.
        base = seen_n;
        set_rand(2);
        req_valid[2] = 1'b1;
        wait_grant(2);
        #2;
        rst_n = 1'b0;
        #1;
        post("midrst_resp_valid", 32'(resp_valid), 32'd0);
        post("midrst_busy", 32'(busy), 32'd0);
        post("midrst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        wait_grant(2);
        req_valid[2] = 1'b0;
        wait_seen(base + 1);
        post("midrst_regrant_id", 32'(seen_id[base % 256]), 32'd2);
        wait_idle();
        repeat (4) step();
        post("midrst_resp_count", 32'(seen_n - base), 32'd1);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
